// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Each slot starts with blanking; new values reach the display only at frame boundaries.
module disp_scan_ctrl #(
    parameter int N_DIG     = 4,
    parameter int DIV       = 50000,
    parameter int GUARD_CYC = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               LOAD,
    input  logic [4*N_DIG-1:0] VAL,
    input  logic               LZ,
    output logic [3:0]         NIB,
    output logic [N_DIG-1:0]   AN,
    output logic               FRAME
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GRD  = CW'(GUARD_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_SHOW} state_t;

    state_t             r_state, w_state_nx;
    logic [CW-1:0]      r_cnt, w_cnt_nx;
    logic [IW-1:0]      r_idx, w_idx_nx;
    logic [4*N_DIG-1:0] r_pend, w_pend_nx;
    logic [4*N_DIG-1:0] r_shd, w_shd_nx;
    logic               r_pv, w_pv_nx;
    logic               w_bound;
    logic               w_allz;
    logic [N_DIG-1:0]   w_sup;
    logic [N_DIG-1:0]   w_an_nx;
    logic [3:0]         w_nib_nx;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_bound    = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_cnt_nx = '0;
                w_idx_nx = '0;
                if (EN) begin
                    w_state_nx = ST_GUARD;
                    w_bound    = 1'b1;
                end
            end
            default: begin
                if (!EN) begin
                    w_state_nx = ST_OFF;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GUARD;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nx = '0;
                        w_bound  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                    w_state_nx = (w_cnt_nx < CNT_GRD) ? ST_GUARD : ST_SHOW;
                end
            end
        endcase

        // A LOAD landing on the frame boundary bypasses PEND so the newest value wins.
        w_pend_nx = r_pend;
        w_pv_nx   = r_pv;
        w_shd_nx  = r_shd;
        if (w_bound) begin
            if (LOAD) begin
                w_shd_nx = VAL;
                w_pv_nx  = 1'b0;
            end else if (r_pv) begin
                w_shd_nx = r_pend;
                w_pv_nx  = 1'b0;
            end
        end else if (LOAD) begin
            w_pend_nx = VAL;
            w_pv_nx   = 1'b1;
        end

        w_allz = 1'b1;
        w_sup  = '0;
        for (int unsigned i = N_DIG - 1; i >= 1; i--) begin
            w_allz   = w_allz && (w_shd_nx[4*i +: 4] == 4'h0);
            w_sup[i] = LZ && w_allz;
        end

        w_nib_nx = '0;
        w_an_nx  = '1;
        if (w_state_nx != ST_OFF)
            w_nib_nx = w_shd_nx[4*w_idx_nx +: 4];
        if (w_state_nx == ST_SHOW && !w_sup[w_idx_nx])
            w_an_nx = ~(N_DIG'(1) << w_idx_nx);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pend  <= '0;
            r_pv    <= 1'b0;
            r_shd   <= '0;
            AN      <= '1;
            NIB     <= '0;
            FRAME   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_pend  <= w_pend_nx;
            r_pv    <= w_pv_nx;
            r_shd   <= w_shd_nx;
            AN      <= w_an_nx;
            NIB     <= w_nib_nx;
            FRAME   <= w_bound;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios then random traffic, checked every
// clock against a frame-position model of the display.
module tb_disp_scan_ctrl;

    localparam int N = 4;
    localparam int D = 8;
    localparam int G = 2;
    localparam int FR = N * D;

    logic        CLK = 1'b0;
    logic        RST, EN, LOAD, LZ;
    logic [15:0] VAL;
    logic [3:0]  NIB;
    logic [3:0]  AN;
    logic        FRAME;

    int total = 0;
    int bad   = 0;

    // Model: scanning flag, clocks elapsed in the current frame, data registers.
    bit          m_on;
    int          m_pos;
    logic [15:0] m_pend, m_shd;
    bit          m_pv, m_frame, m_lz;

    always #5 CLK = ~CLK;

    disp_scan_ctrl #(.N_DIG(N), .DIV(D), .GUARD_CYC(G)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .VAL(VAL), .LZ(LZ),
        .NIB(NIB), .AN(AN), .FRAME(FRAME)
    );

    function automatic logic [3:0] exp_nib();
        int idx;
        if (!m_on) return 4'h0;
        idx = (m_pos / D) % N;
        return 4'((m_shd >> (4 * idx)) & 16'h000F);
    endfunction

    function automatic logic [3:0] exp_an();
        int idx, cnt;
        if (!m_on) return 4'hF;
        idx = (m_pos / D) % N;
        cnt = m_pos % D;
        if (cnt < G) return 4'hF;
        if (m_lz && idx != 0 && (m_shd >> (4 * idx)) == 16'h0) return 4'hF;
        return ~(4'b0001 << idx);
    endfunction

    task automatic model_edge();
        bit bound = 0;
        if (RST) begin
            m_on = 0; m_pos = 0; m_pend = '0; m_pv = 0; m_shd = '0; m_frame = 0;
        end else begin
            if (!m_on) begin
                if (EN) begin m_on = 1; m_pos = 0; bound = 1; end
            end else if (!EN) begin
                m_on = 0; m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
                if (m_pos == FR) begin m_pos = 0; bound = 1; end
            end
            m_frame = bound;
            if (bound) begin
                if (LOAD) begin m_shd = VAL; m_pv = 0; end
                else if (m_pv) begin m_shd = m_pend; m_pv = 0; end
            end else if (LOAD) begin
                m_pend = VAL; m_pv = 1;
            end
        end
        m_lz = LZ;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("AN", 16'(AN), 16'(exp_an()));
        chk("NIB", 16'(NIB), 16'(exp_nib()));
        chk("FRAME", 16'(FRAME), 16'(m_frame));
        chk("AN_ONEHOT", 16'($countones(~AN) <= 1), 16'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 200 && !(m_on && m_pos == pos); k++) tick();
        chk("REACH_POS", 16'(m_on && m_pos == pos), 16'd1);
    endtask

    task automatic load(input logic [15:0] v);
        LOAD = 1'b1; VAL = v;
        tick();
        LOAD = 1'b0;
    endtask

    initial begin
        logic [3:0] an_t [4];
        logic [3:0] nib_t[4];
        an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        nib_t = '{4'h4, 4'h3, 4'h2, 4'h1};
        m_on = 0; m_pos = 0; m_pend = '0; m_shd = '0; m_pv = 0; m_frame = 0; m_lz = 0;

        // Reset dominates EN and LOAD
        RST = 1'b1; EN = 1'b1; LOAD = 1'b1; VAL = 16'hFFFF; LZ = 1'b0;
        #1;
        run(3);
        chk("RST_AN", 16'(AN), 16'hF);
        chk("RST_NIB", 16'(NIB), 16'h0);
        RST = 1'b0; LOAD = 1'b0;
        tick();
        chk("START_FRAME", 16'(FRAME), 16'd1);
        chk("START_NIB", 16'(NIB), 16'h0);
        tick();
        chk("FRAME_ONE_CLK", 16'(FRAME), 16'd0);

        // Scan order
        EN = 1'b0;
        tick();
        load(16'h1234);
        EN = 1'b1;
        tick();
        chk("EN_FRAME", 16'(FRAME), 16'd1);
        for (int s = 0; s < 4; s++) begin
            run_to(s * D + G - 1);
            chk("SLOT_GUARD_AN", 16'(AN), 16'hF);
            tick();
            chk("SLOT_AN", 16'(AN), 16'(an_t[s]));
            chk("SLOT_NIB", 16'(NIB), 16'(nib_t[s]));
        end
        run_to(FR - 1);
        tick();
        chk("FRAME_32", 16'(FRAME), 16'd1);

        // Tear-free update
        run_to(D + 3);
        load(16'hABCD);
        run_to(2 * D + G);
        chk("TEAR_IDX2", 16'(NIB), 16'h2);
        run_to(3 * D + G);
        chk("TEAR_IDX3", 16'(NIB), 16'h1);
        run_to(G);
        chk("NEW_IDX0", 16'(NIB), 16'hD);
        run_to(D + G);
        chk("NEW_IDX1", 16'(NIB), 16'hC);

        // Leading-zero suppression
        LZ = 1'b1;
        load(16'h0050);
        run_to(G);
        chk("LZ_D0_AN", 16'(AN), 16'hE);
        chk("LZ_D0_NIB", 16'(NIB), 16'h0);
        run_to(D + G);
        chk("LZ_D1_AN", 16'(AN), 16'hD);
        chk("LZ_D1_NIB", 16'(NIB), 16'h5);
        run_to(2 * D + G);
        chk("LZ_D2_AN", 16'(AN), 16'hF);
        run_to(3 * D + G);
        chk("LZ_D3_AN", 16'(AN), 16'hF);
        load(16'h0000);
        run_to(G);
        chk("LZ0_D0_AN", 16'(AN), 16'hE);
        run_to(D + G);
        chk("LZ0_D1_AN", 16'(AN), 16'hF);
        LZ = 1'b0;
        run_to(3 * D + G);
        chk("NOLZ_D3_AN", 16'(AN), 16'h7);

        // EN drop mid-slot
        load(16'h5A3C);
        run_to(2 * D + 4);
        EN = 1'b0;
        tick();
        chk("DROP_AN", 16'(AN), 16'hF);
        chk("DROP_NIB", 16'(NIB), 16'h0);
        chk("DROP_FRAME", 16'(FRAME), 16'd0);
        run(3);
        EN = 1'b1;
        tick();
        chk("RESUME_FRAME", 16'(FRAME), 16'd1);
        chk("RESUME_AN", 16'(AN), 16'hF);
        run_to(G);
        chk("RESUME_D0", 16'(NIB), 16'hC);

        // LOAD exactly on the frame boundary
        run_to(FR - 1);
        load(16'h9876);
        chk("BND_NIB", 16'(NIB), 16'h6);
        chk("BND_FRAME", 16'(FRAME), 16'd1);
        run_to(FR - 1);
        tick();
        chk("BND_HOLD", 16'(NIB), 16'h6);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            RST  = ($urandom % 300) == 0;
            EN   = ($urandom % 40) != 0;
            LOAD = ($urandom % 6) == 0;
            VAL  = 16'($urandom) >> ($urandom % 17);
            LZ   = ($urandom % 4) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. All digits share one hex-to-7-segment decoder. Each digit slot, the block presents one nibble to the decoder and drives that digit's active-low enable. It adds:
- a ghost-guard blanking interval at the start of every slot;
- tear-free, frame-synchronous value updates;
- optional leading-zero suppression.

Parameters:
N_DIG, 4, number of digits scanned (>=2)
DIV, 50000, clocks per digit slot (>=2)
GUARD_CYC, 2, blanking clocks at the start of each slot (1 <= GUARD_CYC < DIV)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
EN  in  1  scan enable; 0 = display dark
LOAD  in  1  one-clock strobe: capture VAL
VAL  in  4*N_DIG  digit values; digit i = VAL[4i+3:4i], digit 0 = rightmost
LZ  in  1  1 = suppress leading zeros
NIB  out  4  nibble to the shared decoder's G input
AN  out  N_DIG  digit enables, active-low, at most one bit low
FRAME  out  1  one-clock pulse at each frame start

Behaviour:
Registers and outputs:
- State registers: state (OFF/GUARD/SHOW), slot counter CNT (0..DIV-1), digit index IDX (0..N_DIG-1), pending register PEND with valid flag PV, shadow register SHD.
- AN, NIB and FRAME are registers updated on the same edge as the state registers. There is no extra output latency.

Reset:
- RST=1 at an edge sets: state=OFF, CNT=0, IDX=0, PEND=0, PV=0, SHD=0, AN=all ones, NIB=0, FRAME=0.
- RST overrides EN and LOAD.
- RST mid-scan returns to OFF on that edge.

LOAD:
- LOAD=1 at an edge: PEND<=VAL, PV<=1.
- LOAD is legal in any state.

OFF:
- AN=all ones, NIB=0, CNT=0, IDX=0.
- EN=1 sampled: next state=GUARD, CNT=0, IDX=0, FRAME<=1.
- On that same edge, SHD<=PEND if PV, then PV<=0.

GUARD / SHOW (only while EN=1):
- CNT increments by 1 each clock.
- State is GUARD while CNT<GUARD_CYC, otherwise SHOW.
- GUARD: AN=all ones, NIB=SHD digit IDX (pre-settled for the decoder).
- SHOW: NIB=SHD digit IDX.
  - AN[IDX]=0 and all other bits 1, unless digit IDX is suppressed.
  - If suppressed, AN=all ones for the whole slot.
- At CNT=DIV-1: CNT<=0, IDX<=(IDX+1) mod N_DIG, state<=GUARD.
- Slot length is exactly DIV clocks.
- On the wrap from IDX=N_DIG-1 to 0 (frame boundary):
  - FRAME<=1 for one clock;
  - SHD<=PEND if PV, and PV<=0.
- SHD never changes mid-frame.

LOAD coincident with frame boundary (or with the OFF->GUARD edge):
- SHD<=VAL directly; PV<=0.
- The newest data wins.

EN=0 sampled in GUARD or SHOW:
- Next edge: state=OFF, AN=all ones, NIB=0, CNT=0, IDX=0.
- PEND, PV and SHD are retained.
- No FRAME pulse.

Leading-zero suppression:
- Digit i is suppressed iff LZ=1, i!=0, and SHD digits i..N_DIG-1 are all 0.
- Digit 0 is never suppressed, so an all-zero value shows "0".
- LZ is sampled combinationally each clock.

Invariants:
- AN is never low during GUARD.
- No two AN bits are ever low at once.
- AN changes occur only at GUARD/SHOW boundaries or on entering OFF.

Test Plan:
(All with N_DIG=4, DIV=8, GUARD_CYC=2.)
1. Reset: RST=1 for 3 clocks with EN=1 and LOAD=1 -> AN=1111, NIB=0, FRAME=0, PV=0 throughout. First edge after RST falls: state=GUARD, FRAME=1 for exactly 1 clock.
2. Scan order: LOAD VAL=16'h1234 while OFF, then EN=1. Each 8-clock slot shows 2 clocks AN=1111 then 6 clocks of the active digit:
   - slot 0: AN=1110, NIB=4
   - slot 1: AN=1101, NIB=3
   - slot 2: AN=1011, NIB=2
   - slot 3: AN=0111, NIB=1
   FRAME pulses every 32 clocks.
3. Tear-free update: running with 16'h1234, LOAD 16'hABCD during IDX=1 -> IDX 2 and 3 still show NIB=2 and 1. From the next frame, NIB sequence is D, C, B, A.
4. Leading-zero suppression: SHD=16'h0050, LZ=1 -> slots 3 and 2 keep AN=1111, slot 1 shows AN=1101/NIB=5, slot 0 shows AN=1110/NIB=0. With SHD=16'h0000, only slot 0 lights, NIB=0. With LZ=0, all four digits light.
5. EN drop: EN=0 at CNT=4 of IDX=2 -> next clock AN=1111, NIB=0, no FRAME. EN=1 again -> restart at IDX=0 with 2 guard clocks, FRAME=1, SHD unchanged.
6. LOAD at frame boundary: LOAD VAL=16'h9876 on the edge IDX 3->0 -> slot 0 of the new frame shows NIB=6, and PV=0 afterwards.
